// File: rtl/alu_serial.sv
// Bit-serial ALU: NOR/XOR/ADD/SUB computed SLICE bits per cycle over WIDTH/SLICE cycles.
// Handshake: a transfer happens on a rising edge where valid && ready; valid holds until it does.
module alu_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam int K  = WIDTH / SLICE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int OW = $clog2(WIDTH);

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b11;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("alu_serial: WIDTH must be >= 2");
    end
    if (WIDTH % SLICE != 0) begin : g_bad_slice
      $error("alu_serial: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;

  logic [OW-1:0]     off;
  logic [SLICE-1:0]  a_sl, b_sl, b_eff, r_sl;
  logic [SLICE:0]    sum;
  logic              is_arith, last, msb_cin;

  // Slice datapath: one SLICE-wide ripple adder fed by the carry register.
  always_comb begin
    off      = OW'(count_q) * OW'(SLICE);
    a_sl     = a_q[off +: SLICE];
    b_sl     = b_q[off +: SLICE];
    is_arith = op_q[1];
    b_eff    = (op_q == OP_SUB) ? ~b_sl : b_sl;
    sum      = {1'b0, a_sl} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from the sum bit; on the last slice this is the word MSB.
    msb_cin  = a_sl[SLICE-1] ^ b_eff[SLICE-1] ^ sum[SLICE-1];
    last     = (count_q == CW'(K - 1));
    case (op_q)
      OP_NOR:  r_sl = ~(a_sl | b_sl);
      OP_XOR:  r_sl = a_sl ^ b_sl;
      default: r_sl = sum[SLICE-1:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    s_d       = s_q;
    cout_d    = cout_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_RUN: begin
        busy                = 1'b1;
        res_d[off +: SLICE] = r_sl;
        carry_d             = is_arith & sum[SLICE];
        count_d             = count_q + CW'(1);
        if (last) begin
          state_d = S_DONE;
          count_d = '0;
          s_d     = res_d;
          cout_d  = is_arith & sum[SLICE];
          ovf_d   = is_arith & (msb_cin ^ sum[SLICE]);
          zero_d  = (res_d == '0);
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Accept overrides the DONE->IDLE exit so back-to-back sets see no bubble.
    if (in_valid && in_ready) begin
      a_d     = a;
      b_d     = b;
      op_d    = op;
      carry_d = op[1] & cin;
      count_d = '0;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      res_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign s           = s_q;
  assign cout        = cout_q;
  assign zero        = zero_q;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: three instances (SLICE 1, 2, 4) at WIDTH 8, checked against an arithmetic model.
module tb_alu_serial;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] in_valid, out_ready;
  logic [2:0] in_ready, out_valid, cout, zero, ovf, busy;
  logic [7:0] a [3];
  logic [7:0] b [3];
  logic [2:0] cin;
  logic [1:0] op [3];
  logic [7:0] s [3];
  logic [1:0] dbg [3];

  int checks = 0;
  int errors = 0;

  alu_serial #(.WIDTH(8), .SLICE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .op(op[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .s(s[0]), .cout(cout[0]), .zero(zero[0]),
    .ovf(ovf[0]), .busy(busy[0]), .dbg_state_o(dbg[0]));

  alu_serial #(.WIDTH(8), .SLICE(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]), .op(op[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .s(s[1]), .cout(cout[1]), .zero(zero[1]),
    .ovf(ovf[1]), .busy(busy[1]), .dbg_state_o(dbg[1]));

  alu_serial #(.WIDTH(8), .SLICE(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .cin(cin[2]), .op(op[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .s(s[2]), .cout(cout[2]), .zero(zero[2]),
    .ovf(ovf[2]), .busy(busy[2]), .dbg_state_o(dbg[2]));

  // Slices per operation for instance d (SLICE = 1, 2, 4).
  function automatic int k_of(input int d);
    return 8 >> d;
  endfunction

  // Reference result packed as {zero, ovf, cout, s}.
  function automatic logic [10:0] ref_alu(input logic [1:0] o, input logic [7:0] x,
                                          input logic [7:0] y, input logic ci);
    logic [7:0] r, yy;
    logic       c, v;
    int         uv, sv;
    c = 1'b0;
    v = 1'b0;
    if (o == 2'b00) r = ~(x | y);
    else if (o == 2'b01) r = x ^ y;
    else begin
      yy = (o == 2'b11) ? ~y : y;
      uv = int'(x) + int'(yy) + int'(ci);
      sv = int'($signed(x)) + int'($signed(yy)) + int'(ci);
      r  = uv[7:0];
      c  = (uv > 255);
      v  = (sv > 127) || (sv < -128);
    end
    return {(r == 8'h00), v, c, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int d, input logic [1:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic ci, input int stall,
                         input string tag);
    logic [10:0] e;
    int          n;
    int          cyc;
    e = ref_alu(o, x, y, ci);
    n = 0;
    while (in_ready[d] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s.in_ready_wait d=%0d got %b exp 1", tag, d, in_ready[d]);
      return;
    end
    in_valid[d]  = 1'b1;
    a[d]         = x;
    b[d]         = y;
    cin[d]       = ci;
    op[d]        = o;
    out_ready[d] = (stall == 0);
    tick();
    // Scramble inputs while the operation is in flight.
    in_valid[d] = 1'b0;
    a[d]        = 8'($urandom);
    b[d]        = 8'($urandom);
    cin[d]      = 1'($urandom);
    op[d]       = 2'($urandom);
    checks++;
    if ({busy[d], in_ready[d], out_valid[d]} !== 3'b100) begin
      errors++;
      $display("FAIL %s.run_flags d=%0d got %b exp 100", tag, d,
               {busy[d], in_ready[d], out_valid[d]});
    end
    cyc = 1;
    while (out_valid[d] !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== k_of(d) + 1) begin
      errors++;
      $display("FAIL %s.latency d=%0d got %0d exp %0d", tag, d, cyc, k_of(d) + 1);
    end
    checks++;
    if ({zero[d], ovf[d], cout[d], s[d]} !== e) begin
      errors++;
      $display("FAIL %s.result d=%0d op=%0d a=%h b=%h cin=%b got %h exp %h", tag, d, o, x, y,
               ci, {zero[d], ovf[d], cout[d], s[d]}, e);
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      checks++;
      if ({out_valid[d], in_ready[d], busy[d], zero[d], ovf[d], cout[d], s[d]} !== {3'b100, e}) begin
        errors++;
        $display("FAIL %s.hold d=%0d got %h exp %h", tag, d,
                 {out_valid[d], in_ready[d], busy[d], zero[d], ovf[d], cout[d], s[d]},
                 {3'b100, e});
      end
    end
    out_ready[d] = 1'b1;
    tick();
    checks++;
    if ({out_valid[d], busy[d], in_ready[d]} !== 3'b001) begin
      errors++;
      $display("FAIL %s.release d=%0d got %b exp 001", tag, d,
               {out_valid[d], busy[d], in_ready[d]});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b1;
      out_ready[d] = 1'b1;
      a[d]         = 8'($urandom);
      b[d]         = 8'($urandom);
      cin[d]       = 1'b1;
      op[d]        = 2'b10;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({out_valid[d], busy[d], s[d], cout[d], zero[d], ovf[d]} !== {2'b00, 8'h00, 3'b010}) begin
        errors++;
        $display("FAIL reset.outputs d=%0d got %h exp %h", d,
                 {out_valid[d], busy[d], s[d], cout[d], zero[d], ovf[d]},
                 {2'b00, 8'h00, 3'b010});
      end
    end
    rst_n    = 1'b1;
    in_valid = 3'b000;
    tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({in_ready[d], busy[d], out_valid[d]} !== 3'b100) begin
        errors++;
        $display("FAIL reset.idle d=%0d got %b exp 100", d, {in_ready[d], busy[d], out_valid[d]});
      end
    end
  endtask

  task automatic test_directed();
    run_txn(0, 2'b10, 8'h7F, 8'h01, 1'b0, 0, "add_ovf");
    run_txn(1, 2'b11, 8'h05, 8'h05, 1'b1, 0, "sub_zero");
    run_txn(2, 2'b00, 8'hF0, 8'h0C, 1'b1, 0, "nor");
    run_txn(2, 2'b01, 8'hAA, 8'hFF, 1'b1, 0, "xor");
    run_txn(0, 2'b11, 8'h80, 8'h01, 1'b1, 0, "sub_ovf");
    run_txn(1, 2'b10, 8'hFF, 8'hFF, 1'b1, 0, "add_max");
  endtask

  task automatic test_back_to_back();
    logic [10:0] e1, e2;
    int          cyc;
    e1 = ref_alu(2'b10, 8'hFF, 8'h01, 1'b0);
    e2 = ref_alu(2'b10, 8'h01, 8'h01, 1'b0);
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b1; out_ready[d] = 1'b1;
      op[d] = 2'b10; a[d] = 8'hFF; b[d] = 8'h01; cin[d] = 1'b0;
      tick();
      a[d] = 8'h01;
      cyc = 1;
      while (out_valid[d] !== 1'b1 && cyc < 40) begin tick(); cyc++; end
      checks++;
      if ({cyc, in_ready[d], zero[d], ovf[d], cout[d], s[d]} !== {k_of(d) + 1, 1'b1, e1}) begin
        errors++;
        $display("FAIL b2b.first d=%0d got cyc=%0d rdy=%b %h exp cyc=%0d rdy=1 %h", d, cyc,
                 in_ready[d], {zero[d], ovf[d], cout[d], s[d]}, k_of(d) + 1, e1);
      end
      tick();
      in_valid[d] = 1'b0;
      checks++;
      if ({busy[d], out_valid[d]} !== 2'b10) begin
        errors++;
        $display("FAIL b2b.no_bubble d=%0d got %b exp 10", d, {busy[d], out_valid[d]});
      end
      cyc = 1;
      while (out_valid[d] !== 1'b1 && cyc < 40) begin tick(); cyc++; end
      checks++;
      if ({cyc, zero[d], ovf[d], cout[d], s[d]} !== {k_of(d) + 1, e2}) begin
        errors++;
        $display("FAIL b2b.second d=%0d got cyc=%0d %h exp cyc=%0d %h", d, cyc,
                 {zero[d], ovf[d], cout[d], s[d]}, k_of(d) + 1, e2);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int seen;
    for (int d = 0; d < 3; d++) begin
      run_txn(d, 2'b11, 8'h3C, 8'h5A, 1'b1, 5, "bp");
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        if (out_valid[d] === 1'b1) seen++;
        tick();
      end
      checks++;
      if (seen !== 0) begin
        errors++;
        $display("FAIL bp.once d=%0d got %0d extra valid cycles exp 0", d, seen);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] pick [5];
    logic [7:0] x, y;
    pick[0] = 8'h00; pick[1] = 8'hFF; pick[2] = 8'h7F; pick[3] = 8'h80; pick[4] = 8'h01;
    for (int i = 0; i < 40; i++) begin
      x = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : 8'($urandom);
      y = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : 8'($urandom);
      run_txn($urandom_range(0, 2), 2'($urandom), x, y, 1'($urandom),
              $urandom_range(0, 3), "rand");
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    op[0] = 2'b10; a[0] = 8'h12; b[0] = 8'h34; cin[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    rst_n    = 1'b0;
    in_valid = 3'b111;
    tick();
    rst_n    = 1'b1;
    in_valid = 3'b000;
    checks++;
    if ({in_ready[0], busy[0], out_valid[0], dbg[0], s[0], zero[0]} !== {3'b100, 2'd0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid.idle got %h exp %h",
               {in_ready[0], busy[0], out_valid[0], dbg[0], s[0], zero[0]},
               {3'b100, 2'd0, 8'h00, 1'b1});
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid[0] === 1'b1 || busy[0] === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_mid.no_valid got %0d active cycles exp 0", seen);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 3'b000;
    out_ready = 3'b111;
    cin       = 3'b000;
    for (int d = 0; d < 3; d++) begin
      a[d] = 8'h00; b[d] = 8'h00; op[d] = 2'b00;
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter SLICE, default 1, bits processed per cycle; WIDTH % SLICE != 0 SHALL cause an elaboration error.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry in, used by ADD/SUB only.
REQ-010 op  input  2  00 NOR, 01 XOR, 10 ADD, 11 SUB.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 s  output  WIDTH  result.
REQ-014 cout  output  1  final carry out.
REQ-015 zero  output  1  s == 0.
REQ-016 ovf  output  1  signed overflow.
REQ-017 busy  output  1  high in RUN state.

Function
REQ-018 FSM states IDLE, RUN, DONE; K = WIDTH/SLICE.
REQ-019 IDLE: in_ready=1; on in_valid&&in_ready, register a, b, op, carry<=cin (carry<=0 for NOR/XOR), count<=0, go RUN.
REQ-020 RUN: each cycle process bits [count*SLICE +: SLICE] of registered operands, write into same bits of result register, update carry, count++; after K cycles go DONE.
REQ-021 Per-bit ops: NOR ~(a|b); XOR a^b; ADD a+b+carry; SUB a+~b+carry (cin=1 gives true a-b).
REQ-022 Carry SHALL ripple across slices exactly as a WIDTH-bit adder; result of ADD/SUB SHALL equal (a op b + cin) mod 2^WIDTH.
REQ-023 cout = carry out of bit WIDTH-1 for ADD/SUB; 0 for NOR/XOR.
REQ-024 ovf = carry into MSB XOR carry out of MSB for ADD/SUB; 0 for NOR/XOR.
REQ-025 zero = (s == 0) for all ops.
REQ-026 Latency: out_valid asserts exactly K+1 cycles after the accepting edge (K RUN cycles, then DONE).
REQ-027 DONE: out_valid=1; s, cout, zero, ovf SHALL be stable until out_valid&&out_ready.
REQ-028 DONE: in_ready = out_ready; in_valid&&out_ready in the same cycle SHALL complete the result and accept the new set (go RUN), no bubble.
REQ-029 DONE with out_ready=1 and in_valid=0 SHALL go IDLE.
REQ-030 RUN: in_ready=0, out_valid=0; input changes SHALL NOT affect the operation in flight.
REQ-031 busy=1 only in RUN.
REQ-032 Outputs s, cout, zero, ovf SHALL hold last completed values outside DONE (not meaningful while out_valid=0).

Reset
REQ-033 rst_n=0 at a rising edge: state IDLE, count=0, carry=0, result register=0, out_valid=0, busy=0, in_ready=1 from next cycle, s=0, cout=0, zero=1, ovf=0.
REQ-034 Reset in RUN or DONE SHALL discard the operation; no out_valid follows.
REQ-035 While rst_n=0, in_valid SHALL be ignored.

Verification
REQ-036 WIDTH=8, SLICE=1: ADD a=0x7F b=0x01 cin=0 -> out_valid 9 cycles after accept, s=0x80, cout=0, ovf=1, zero=0.
REQ-037 WIDTH=8, SLICE=2: SUB a=0x05 b=0x05 cin=1 -> s=0x00, cout=1, zero=1, ovf=0, out_valid 5 cycles after accept.
REQ-038 WIDTH=8, SLICE=4: NOR a=0xF0 b=0x0C cin=1 -> s=0x03, cout=0, ovf=0; XOR a=0xAA b=0xFF -> s=0x55.
REQ-039 Back-to-back: hold out_ready=1, in_valid=1 with ADD 0xFF+0x01 then ADD 0x01+0x01 -> results 0x00 (cout=1, zero=1) then 0x02, no idle cycle between accepts.
REQ-040 Backpressure: out_ready=0 for 5 cycles in DONE -> s/flags stable, in_ready=0; then out_ready=1 -> completes once.
REQ-041 Reset mid-RUN (cycle 3 of ADD) -> next cycle IDLE, in_ready=1, out_valid never asserts for that op.
